// File: rtl/mips32_pipeline_core.sv
// Five-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB) with internal unified memory
// and register file; no interlocks or forwarding beyond the WB->ID write-before-read bypass.
module mips32_pipeline_core #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        halted,
  output logic [31:0] pc
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_LW, K_SW, K_BNEQZ, K_BEQZ, K_HLT} kind_e;
  typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT, A_MUL} aluop_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ifid_t;

  typedef struct packed {
    kind_e       kind;
    aluop_e      op;
    logic        use_imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  dst;
  } idex_t;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  dst;
  } exmem_t;

  typedef struct packed {
    kind_e       kind;
    logic [31:0] val;
    logic [4:0]  dst;
  } memwb_t;

  // Opcode 111110 is unassigned and therefore decodes as a NOP.
  localparam ifid_t  IFID_BUBBLE  = '{ir: 32'hf800_0000, npc: 32'd0};
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  logic [31:0] regs [0:31];
  logic [31:0] mem  [0:MEM_DEPTH-1];

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic        taken_q;
  ifid_t       ifid_q, ifid_d;
  idex_t       idex_q, idex_d, id_dec;
  exmem_t      exmem_q, exmem_d;
  memwb_t      memwb_q, memwb_d;

  logic [4:0]  id_rs, id_rt;
  logic        wb_we;
  logic [31:0] ex_opb, ex_res, ex_target;
  logic        ex_taken, fetch_stop;

  assign pc     = pc_q;
  assign halted = halted_q;

  assign id_rs = ifid_q.ir[25:21];
  assign id_rt = ifid_q.ir[20:16];
  assign wb_we = (memwb_q.kind == K_ALU || memwb_q.kind == K_LW) && (memwb_q.dst != 5'd0);

  // ID: decode plus register read with same-cycle WB bypass
  always_comb begin
    id_dec         = IDEX_BUBBLE;
    id_dec.imm     = {{16{ifid_q.ir[15]}}, ifid_q.ir[15:0]};
    id_dec.npc     = ifid_q.npc;
    id_dec.dst     = ifid_q.ir[15:11];
    id_dec.a       = (id_rs == 5'd0) ? '0 :
                     (wb_we && memwb_q.dst == id_rs) ? memwb_q.val : regs[id_rs];
    id_dec.b       = (id_rt == 5'd0) ? '0 :
                     (wb_we && memwb_q.dst == id_rt) ? memwb_q.val : regs[id_rt];
    case (opcode_e'(ifid_q.ir[31:26]))
      OP_ADD:   begin id_dec.kind = K_ALU; id_dec.op = A_ADD; end
      OP_SUB:   begin id_dec.kind = K_ALU; id_dec.op = A_SUB; end
      OP_AND:   begin id_dec.kind = K_ALU; id_dec.op = A_AND; end
      OP_OR:    begin id_dec.kind = K_ALU; id_dec.op = A_OR;  end
      OP_SLT:   begin id_dec.kind = K_ALU; id_dec.op = A_SLT; end
      OP_MUL:   begin id_dec.kind = K_ALU; id_dec.op = A_MUL; end
      OP_ADDI:  begin id_dec.kind = K_ALU; id_dec.op = A_ADD; id_dec.use_imm = 1'b1; id_dec.dst = id_rt; end
      OP_SUBI:  begin id_dec.kind = K_ALU; id_dec.op = A_SUB; id_dec.use_imm = 1'b1; id_dec.dst = id_rt; end
      OP_SLTI:  begin id_dec.kind = K_ALU; id_dec.op = A_SLT; id_dec.use_imm = 1'b1; id_dec.dst = id_rt; end
      OP_LW:    begin id_dec.kind = K_LW;  id_dec.use_imm = 1'b1; id_dec.dst = id_rt; end
      OP_SW:    begin id_dec.kind = K_SW;  id_dec.use_imm = 1'b1; end
      OP_BNEQZ: id_dec.kind = K_BNEQZ;
      OP_BEQZ:  id_dec.kind = K_BEQZ;
      OP_HLT:   id_dec.kind = K_HLT;
      default:  id_dec.kind = K_NOP;
    endcase
    // The slot right after a taken branch only ever holds a flushed fetch.
    if (taken_q) id_dec.kind = K_NOP;
  end

  // EX: ALU / effective address and branch resolution
  always_comb begin
    ex_opb = idex_q.use_imm ? idex_q.imm : idex_q.b;
    ex_res = '0;
    case (idex_q.op)
      A_ADD:   ex_res = idex_q.a + ex_opb;
      A_SUB:   ex_res = idex_q.a - ex_opb;
      A_AND:   ex_res = idex_q.a & ex_opb;
      A_OR:    ex_res = idex_q.a | ex_opb;
      A_SLT:   ex_res = ($signed(idex_q.a) < $signed(ex_opb)) ? 32'd1 : 32'd0;
      A_MUL:   ex_res = idex_q.a * ex_opb;
      default: ex_res = '0;
    endcase
    ex_target = idex_q.npc + idex_q.imm;
    ex_taken  = (idex_q.kind == K_BNEQZ && idex_q.a != 32'd0) ||
                (idex_q.kind == K_BEQZ  && idex_q.a == 32'd0);
  end

  assign fetch_stop = (id_dec.kind == K_HLT) || (idex_q.kind == K_HLT) ||
                      (exmem_q.kind == K_HLT) || (memwb_q.kind == K_HLT);

  always_comb begin
    pc_d       = pc_q + 32'd1;
    ifid_d.ir  = mem[pc_q[AW-1:0]];
    ifid_d.npc = pc_q + 32'd1;
    idex_d     = id_dec;
    // An older taken branch wins over an HLT sitting in ID.
    if (ex_taken) begin
      pc_d   = ex_target;
      ifid_d = IFID_BUBBLE;
      idex_d = IDEX_BUBBLE;
    end else if (fetch_stop) begin
      pc_d   = pc_q;
      ifid_d = IFID_BUBBLE;
    end
    exmem_d      = '{kind: idex_q.kind, alu: ex_res, b: idex_q.b, dst: idex_q.dst};
    memwb_d.kind = exmem_q.kind;
    memwb_d.dst  = exmem_q.dst;
    memwb_d.val  = (exmem_q.kind == K_LW) ? mem[exmem_q.alu[AW-1:0]] : exmem_q.alu;
    halted_d     = (memwb_q.kind == K_HLT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
      taken_q  <= 1'b0;
      ifid_q   <= IFID_BUBBLE;
      idex_q   <= IDEX_BUBBLE;
      exmem_q  <= EXMEM_BUBBLE;
      memwb_q  <= MEMWB_BUBBLE;
    end else if (!halted_q) begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
      taken_q  <= ex_taken;
      ifid_q   <= ifid_d;
      idex_q   <= idex_d;
      exmem_q  <= exmem_d;
      memwb_q  <= memwb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !halted_q && wb_we) regs[memwb_q.dst] <= memwb_q.val;
  end

  always_ff @(posedge clk) begin
    if (!rst && !halted_q && exmem_q.kind == K_SW) mem[exmem_q.alu[AW-1:0]] <= exmem_q.b;
  end

endmodule

// File: tb/tb_mips32_pipeline_core.sv
// Directed-program bench for mips32_pipeline_core: preloads memory/registers hierarchically,
// runs each program to HLT and checks hand-computed architectural results.
module tb_mips32_pipeline_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [31:0] pc;
  int          tests = 0;
  int          fails = 0;

  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_AND = 6'b000010,
                         O_OR = 6'b000011, O_SLT = 6'b000100, O_MUL = 6'b000101,
                         O_LW = 6'b001000, O_SW = 6'b001001, O_ADDI = 6'b001010,
                         O_SUBI = 6'b001011, O_SLTI = 6'b001100, O_BNEQZ = 6'b001101,
                         O_BEQZ = 6'b001110;
  localparam logic [31:0] FILL = 32'h0ce77800;
  localparam logic [31:0] HLT  = 32'hfc000000;

  mips32_pipeline_core #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic prep();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 1024; i++) dut.mem[i] = '0;
    for (int i = 0; i < 32; i++) dut.regs[i] = '0;
  endtask

  task automatic run_to_halt(input int maxc, output int ncyc);
    ncyc = 0;
    while (halted !== 1'b1 && ncyc < maxc) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic load_loop();
    dut.mem[0]  = enc_i(O_ADDI, 5'd0, 5'd10, 16'd200);
    dut.mem[1]  = enc_i(O_ADDI, 5'd0, 5'd2, 16'd1);
    dut.mem[2]  = FILL;
    dut.mem[3]  = enc_i(O_LW, 5'd10, 5'd3, 16'd0);
    dut.mem[4]  = FILL;
    dut.mem[5]  = FILL;
    dut.mem[6]  = enc_r(O_MUL, 5'd2, 5'd3, 5'd2);
    dut.mem[7]  = enc_i(O_SUBI, 5'd3, 5'd3, 16'd1);
    dut.mem[8]  = FILL;
    dut.mem[9]  = FILL;
    dut.mem[10] = enc_i(O_BNEQZ, 5'd3, 5'd0, 16'hfffb);
    dut.mem[11] = enc_i(O_ADDI, 5'd20, 5'd20, 16'd1);
    dut.mem[12] = enc_i(O_SW, 5'd10, 5'd2, 16'hfffe);
    dut.mem[13] = HLT;
    dut.mem[200] = 32'd7;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h, expected 00000000", pc); end
    tests++;
    if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b, expected 0", halted); end
  endtask

  task automatic test_alu_program();
    int n;
    prep();
    dut.mem[0] = 32'h2801000a; dut.mem[1] = 32'h28020014; dut.mem[2] = 32'h28030019;
    dut.mem[3] = FILL;         dut.mem[4] = FILL;         dut.mem[5] = 32'h00222000;
    dut.mem[6] = FILL;         dut.mem[7] = FILL;         dut.mem[8] = 32'h00832800;
    dut.mem[9] = HLT;
    rst = 1'b0;
    run_to_halt(200, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL alu_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.regs[1] !== 32'd10) begin fails++; $display("FAIL alu_r1: got %0d, expected 10", dut.regs[1]); end
    tests++;
    if (dut.regs[2] !== 32'd20) begin fails++; $display("FAIL alu_r2: got %0d, expected 20", dut.regs[2]); end
    tests++;
    if (dut.regs[3] !== 32'd25) begin fails++; $display("FAIL alu_r3: got %0d, expected 25", dut.regs[3]); end
    tests++;
    if (dut.regs[4] !== 32'd30) begin fails++; $display("FAIL alu_r4: got %0d, expected 30", dut.regs[4]); end
    tests++;
    if (dut.regs[5] !== 32'd55) begin fails++; $display("FAIL alu_r5: got %0d, expected 55", dut.regs[5]); end
    tests++;
    if (pc !== 32'd10) begin fails++; $display("FAIL alu_pc_at_halt: got %0d, expected 10", pc); end
    repeat (8) @(negedge clk);
    tests++;
    if (pc !== 32'd10 || halted !== 1'b1) begin
      fails++; $display("FAIL alu_frozen: pc=%0d halted=%b, expected pc=10 halted=1", pc, halted);
    end
  endtask

  task automatic test_load_store();
    int n;
    prep();
    dut.mem[0] = enc_i(O_LW, 5'd0, 5'd2, 16'd120);
    dut.mem[1] = FILL;
    dut.mem[2] = FILL;
    dut.mem[3] = enc_i(O_ADDI, 5'd2, 5'd2, 16'd45);
    dut.mem[4] = FILL;
    dut.mem[5] = FILL;
    dut.mem[6] = enc_i(O_SW, 5'd0, 5'd2, 16'd1);
    dut.mem[7] = HLT;
    dut.mem[120] = 32'd85;
    rst = 1'b0;
    run_to_halt(200, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL ls_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.regs[2] !== 32'd130) begin fails++; $display("FAIL ls_r2: got %0d, expected 130", dut.regs[2]); end
    tests++;
    if (dut.mem[1] !== 32'd130) begin fails++; $display("FAIL ls_mem1: got %0d, expected 130", dut.mem[1]); end
  endtask

  task automatic test_alu_ops();
    int n;
    prep();
    dut.regs[1] = 32'hfffffffb;
    dut.regs[2] = 32'd3;
    dut.mem[0]  = enc_r(O_SUB, 5'd1, 5'd2, 5'd3);
    dut.mem[1]  = enc_r(O_AND, 5'd1, 5'd2, 5'd4);
    dut.mem[2]  = enc_r(O_OR, 5'd1, 5'd2, 5'd5);
    dut.mem[3]  = enc_r(O_SLT, 5'd1, 5'd2, 5'd6);
    dut.mem[4]  = enc_r(O_SLT, 5'd2, 5'd1, 5'd7);
    dut.mem[5]  = enc_r(O_MUL, 5'd1, 5'd2, 5'd8);
    dut.mem[6]  = enc_i(O_SLTI, 5'd1, 5'd9, 16'hfffc);
    dut.mem[7]  = enc_i(O_SUBI, 5'd2, 5'd10, 16'd5);
    dut.mem[8]  = enc_i(O_BEQZ, 5'd2, 5'd0, 16'd5);
    dut.mem[9]  = enc_i(O_BEQZ, 5'd0, 5'd0, 16'd1);
    dut.mem[10] = enc_i(O_ADDI, 5'd0, 5'd11, 16'd99);
    dut.mem[11] = enc_i(O_ADDI, 5'd0, 5'd13, 16'd1);
    dut.mem[12] = enc_i(6'b010000, 5'd1, 5'd1, 16'd7);
    dut.mem[13] = HLT;
    rst = 1'b0;
    run_to_halt(200, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL ops_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.regs[3] !== 32'hfffffff8) begin fails++; $display("FAIL ops_sub: got %h, expected fffffff8", dut.regs[3]); end
    tests++;
    if (dut.regs[4] !== 32'h00000003) begin fails++; $display("FAIL ops_and: got %h, expected 00000003", dut.regs[4]); end
    tests++;
    if (dut.regs[5] !== 32'hfffffffb) begin fails++; $display("FAIL ops_or: got %h, expected fffffffb", dut.regs[5]); end
    tests++;
    if (dut.regs[6] !== 32'd1) begin fails++; $display("FAIL ops_slt_true: got %h, expected 1", dut.regs[6]); end
    tests++;
    if (dut.regs[7] !== 32'd0) begin fails++; $display("FAIL ops_slt_false: got %h, expected 0", dut.regs[7]); end
    tests++;
    if (dut.regs[8] !== 32'hfffffff1) begin fails++; $display("FAIL ops_mul: got %h, expected fffffff1", dut.regs[8]); end
    tests++;
    if (dut.regs[9] !== 32'd1) begin fails++; $display("FAIL ops_slti: got %h, expected 1", dut.regs[9]); end
    tests++;
    if (dut.regs[10] !== 32'hfffffffe) begin fails++; $display("FAIL ops_subi: got %h, expected fffffffe", dut.regs[10]); end
    tests++;
    if (dut.regs[11] !== 32'd0) begin fails++; $display("FAIL ops_flushed: got %0d, expected 0", dut.regs[11]); end
    tests++;
    if (dut.regs[13] !== 32'd1) begin fails++; $display("FAIL ops_branch_target: got %0d, expected 1", dut.regs[13]); end
    tests++;
    if (dut.regs[1] !== 32'hfffffffb) begin fails++; $display("FAIL ops_unknown_nop: got %h, expected fffffffb", dut.regs[1]); end
  endtask

  task automatic test_hazard_r0();
    int n;
    prep();
    dut.regs[4]  = 32'h1234;
    dut.regs[12] = 32'h55;
    dut.mem[0]  = enc_i(O_ADDI, 5'd0, 5'd1, 16'd3);
    dut.mem[1]  = enc_i(O_ADDI, 5'd0, 5'd2, 16'd4);
    dut.mem[2]  = FILL;
    dut.mem[3]  = FILL;
    dut.mem[4]  = enc_r(O_ADD, 5'd1, 5'd2, 5'd4);
    dut.mem[5]  = enc_r(O_ADD, 5'd4, 5'd0, 5'd6);
    dut.mem[6]  = enc_r(O_ADD, 5'd4, 5'd0, 5'd8);
    dut.mem[7]  = enc_r(O_ADD, 5'd4, 5'd0, 5'd9);
    dut.mem[8]  = enc_i(O_ADDI, 5'd0, 5'd0, 16'd5);
    dut.mem[9]  = FILL;
    dut.mem[10] = FILL;
    dut.mem[11] = enc_r(O_ADD, 5'd0, 5'd0, 5'd12);
    dut.mem[12] = HLT;
    rst = 1'b0;
    run_to_halt(200, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL hz_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.regs[4] !== 32'd7) begin fails++; $display("FAIL hz_r4: got %h, expected 7", dut.regs[4]); end
    tests++;
    if (dut.regs[6] !== 32'h1234) begin fails++; $display("FAIL hz_gap1_stale: got %h, expected 1234", dut.regs[6]); end
    tests++;
    if (dut.regs[8] !== 32'h1234) begin fails++; $display("FAIL hz_gap2_stale: got %h, expected 1234", dut.regs[8]); end
    tests++;
    if (dut.regs[9] !== 32'd7) begin fails++; $display("FAIL hz_gap3_bypass: got %h, expected 7", dut.regs[9]); end
    tests++;
    if (dut.regs[0] !== 32'd0) begin fails++; $display("FAIL hz_r0_write: got %h, expected 0", dut.regs[0]); end
    tests++;
    if (dut.regs[12] !== 32'd0) begin fails++; $display("FAIL hz_r0_read: got %h, expected 0", dut.regs[12]); end
  endtask

  task automatic test_loop();
    int n;
    prep();
    load_loop();
    rst = 1'b0;
    run_to_halt(1000, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL loop_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.mem[198] !== 32'd5040) begin fails++; $display("FAIL loop_fact: got %0d, expected 5040", dut.mem[198]); end
    tests++;
    if (dut.regs[3] !== 32'd0) begin fails++; $display("FAIL loop_r3: got %0d, expected 0", dut.regs[3]); end
    tests++;
    if (dut.regs[20] !== 32'd1) begin fails++; $display("FAIL loop_shadow_commits: got %0d, expected 1", dut.regs[20]); end
  endtask

  task automatic test_reset_midrun();
    int n;
    prep();
    load_loop();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (pc !== 32'd0 || halted !== 1'b0) begin
      fails++; $display("FAIL mid_reset_state: pc=%0d halted=%b, expected pc=0 halted=0", pc, halted);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (pc !== 32'd1) begin fails++; $display("FAIL mid_refetch: pc=%0d, expected 1", pc); end
    run_to_halt(1000, n);
    tests++;
    if (halted !== 1'b1) begin fails++; $display("FAIL mid_halt: halted=%b after %0d cycles, expected 1", halted, n); end
    tests++;
    if (dut.mem[198] !== 32'd5040) begin fails++; $display("FAIL mid_fact: got %0d, expected 5040", dut.mem[198]); end
    tests++;
    if (dut.regs[20] !== 32'd1) begin fails++; $display("FAIL mid_shadow_commits: got %0d, expected 1", dut.regs[20]); end
  endtask

  task automatic test_hlt_drain();
    int n;
    prep();
    dut.mem[0]  = enc_i(O_ADDI, 5'd0, 5'd1, 16'd7);
    dut.mem[1]  = HLT;
    dut.mem[2]  = enc_i(O_SW, 5'd0, 5'd1, 16'd50);
    dut.mem[50] = 32'hdead;
    rst = 1'b0;
    run_to_halt(50, n);
    // HLT is fetched on edge 2, so halted must first appear after edge 6
    tests++;
    if (halted !== 1'b1 || n != 6) begin
      fails++; $display("FAIL drain_timing: halted=%b at cycle %0d, expected 1 at cycle 6", halted, n);
    end
    tests++;
    if (pc !== 32'd2) begin fails++; $display("FAIL drain_pc: got %0d, expected 2", pc); end
    repeat (6) @(negedge clk);
    tests++;
    if (dut.mem[50] !== 32'hdead) begin fails++; $display("FAIL drain_sw_blocked: got %h, expected 0000dead", dut.mem[50]); end
    tests++;
    if (dut.regs[1] !== 32'd7) begin fails++; $display("FAIL drain_older_commit: got %0d, expected 7", dut.regs[1]); end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (halted !== 1'b0 || pc !== 32'd0) begin
      fails++; $display("FAIL drain_reset_clears: halted=%b pc=%0d, expected 0/0", halted, pc);
    end
  endtask

  initial begin
    test_reset();
    test_alu_program();
    test_load_store();
    test_alu_ops();
    test_hazard_r0();
    test_loop();
    test_reset_midrun();
    test_hlt_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
